// File: rtl/m_frame_scan_ctrl_640x480_if.sv
// Scan-controller bus: enable and frame-buffer read port in, DAC signals out.
interface m_frame_scan_ctrl_640x480_if;
   logic             piul1Enable;
   logic [16:0]      poul17RAddr;
   logic [2:0][3:0]  piul12RData;
   logic [2:0][3:0]  poul12Rgb;
   logic             poul1HSync;
   logic             poul1VSync;
   logic             poul1Blank;
   logic             poul1FrameDone;

   modport master (
      input  piul1Enable,
      input  piul12RData,
      output poul17RAddr,
      output poul12Rgb,
      output poul1HSync,
      output poul1VSync,
      output poul1Blank,
      output poul1FrameDone
   );

   modport slave (
      output piul1Enable,
      output piul12RData,
      input  poul17RAddr,
      input  poul12Rgb,
      input  poul1HSync,
      input  poul1VSync,
      input  poul1Blank,
      input  poul1FrameDone
   );
endinterface

// File: rtl/m_frame_scan_ctrl_640x480.sv
// 640x480@60 VGA read sequencer for a 320x240 frame buffer with 2x2 pixel
// doubling. Counters -> address -> buffer read -> DAC register, so sync and
// blank are delayed three cycles to line up with the returned pixel.
module m_frame_scan_ctrl_640x480 #(
   parameter int unsigned H_FRONT = 16,
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BACK  = 48,
   parameter int unsigned V_FRONT = 10,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BACK  = 33
) (
   input  logic piul1Clock,
   input  logic piul1Reset,
   m_frame_scan_ctrl_640x480_if.master bus
);
   localparam int unsigned CW       = 10;
   localparam int unsigned AW       = 17;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic [AW-1:0] ROW_STRIDE = AW'(320);

   logic [CW-1:0]   hcnt, vcnt, hcnt_nxt, vcnt_nxt;
   logic [AW-1:0]   line_base, line_base_nxt;
   logic            line_end_c, frame_end_c, active_c, hs_c, vs_c;
   logic [AW-1:0]   raddr;
   logic            blank_d1, hs_d1, vs_d1;
   logic            blank_d2, hs_d2, vs_d2;
   logic [2:0][3:0] rgb;
   logic            hsync, vsync, blank, frame_done;

   // Stage-0 position decodes
   always_comb begin
      line_end_c  = (hcnt == H_LAST);
      frame_end_c = line_end_c && (vcnt == V_LAST);
      active_c    = (hcnt < H_ACT) && (vcnt < V_ACT);
      hs_c        = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
      vs_c        = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
   end

   // Next scan position and row base; each buffer row serves an even/odd line pair
   always_comb begin
      hcnt_nxt      = hcnt + CW'(1);
      vcnt_nxt      = vcnt;
      line_base_nxt = line_base;
      if (line_end_c) begin
         hcnt_nxt = '0;
         if (frame_end_c) begin
            vcnt_nxt      = '0;
            line_base_nxt = '0;
         end else begin
            vcnt_nxt = vcnt + CW'(1);
            if (vcnt[0] && (vcnt < V_ACT)) begin
               line_base_nxt = line_base + ROW_STRIDE;
            end
         end
      end
      if (!bus.piul1Enable) begin
         hcnt_nxt      = '0;
         vcnt_nxt      = '0;
         line_base_nxt = '0;
      end
   end

   // Scan position registers
   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         hcnt      <= '0;
         vcnt      <= '0;
         line_base <= '0;
      end else begin
         hcnt      <= hcnt_nxt;
         vcnt      <= vcnt_nxt;
         line_base <= line_base_nxt;
      end
   end

   // Address, timing delay line and DAC output registers; disable flushes to idle
   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         raddr      <= '0;
         blank_d1   <= 1'b1;
         hs_d1      <= 1'b0;
         vs_d1      <= 1'b0;
         blank_d2   <= 1'b1;
         hs_d2      <= 1'b0;
         vs_d2      <= 1'b0;
         rgb        <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else if (!bus.piul1Enable) begin
         raddr      <= '0;
         blank_d1   <= 1'b1;
         hs_d1      <= 1'b0;
         vs_d1      <= 1'b0;
         blank_d2   <= 1'b1;
         hs_d2      <= 1'b0;
         vs_d2      <= 1'b0;
         rgb        <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         raddr      <= active_c ? (line_base + AW'(hcnt[CW-1:1])) : '0;
         blank_d1   <= !active_c;
         hs_d1      <= hs_c;
         vs_d1      <= vs_c;
         blank_d2   <= blank_d1;
         hs_d2      <= hs_d1;
         vs_d2      <= vs_d1;
         rgb        <= blank_d2 ? '0 : bus.piul12RData;
         hsync      <= !hs_d2;
         vsync      <= !vs_d2;
         blank      <= blank_d2;
         frame_done <= frame_end_c;
      end
   end

   assign bus.poul17RAddr    = raddr;
   assign bus.poul12Rgb      = rgb;
   assign bus.poul1HSync     = hsync;
   assign bus.poul1VSync     = vsync;
   assign bus.poul1Blank     = blank;
   assign bus.poul1FrameDone = frame_done;
endmodule

// File: doc/m_frame_scan_ctrl_640x480.md
# m_frame_scan_ctrl_640x480

Read-side sequencer for the 320x240 12-bit RGB frame buffer. It generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and produces frame-buffer read addresses with 2x horizontal and 2x vertical pixel doubling. It absorbs the buffer's 1-cycle registered read latency and delivers sync, blank and RGB to the ADV7123 DAC interface, all aligned to each other.

## Interface
Parameters:
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch

Active area is fixed at 640x480. The buffer is fixed at 320x240 (17-bit address).

Ports:
- piul1Clock  in  1  pixel clock, 25 MHz
- piul1Reset  in  1  asynchronous, active-high reset
- piul1Enable  in  1  scan enable; low holds the scan at frame origin
- poul17RAddr  out  17  frame-buffer read address
- piul12RData  in  [2:0][3:0]  frame-buffer read data, valid 1 cycle after address
- poul12Rgb  out  [2:0][3:0]  RGB to DAC, zero while blanked
- poul1HSync  out  1  horizontal sync, active low
- poul1VSync  out  1  vertical sync, active low
- poul1Blank  out  1  high outside the active area
- poul1FrameDone  out  1  one-cycle pulse at frame wrap

Reset and synchronicity: one clock; reset is asynchronous and active-high.

## Operation
- Counters: hcnt is 0..799 (H_TOTAL = 640+H_FRONT+H_SYNC+H_BACK); vcnt is 0..524.
  - hcnt wraps to 0 at H_TOTAL-1 and increments vcnt.
  - vcnt wraps to 0 at V_TOTAL-1.
- Stage 0 (counters) decodes:
  - active = hcnt<640 && vcnt<480
  - hs = hcnt in [640+H_FRONT, 640+H_FRONT+H_SYNC-1]
  - vs = vcnt in [480+V_FRONT, 480+V_FRONT+V_SYNC-1]
- Address is computed incrementally; no multiplier.
  - lineBase is 17 bits, reset to 0.
  - At end of each line (hcnt=799) with vcnt odd and vcnt<480, lineBase += 320.
  - At frame wrap, lineBase = 0.
- Stage 1: poul17RAddr <= active ? lineBase + hcnt[9:1] : 0.
  - Maximum address is 76799. Addresses ≥76800 must never be issued.
- Stage 2: the buffer returns piul12RData.
- Stage 3 registers:
  - poul12Rgb <= blank ? 0 : piul12RData
  - poul1HSync, poul1VSync, poul1Blank: stage-0 decodes delayed 3 cycles, syncs inverted to active low.
- poul1FrameDone: registered pulse when hcnt=799 && vcnt=524. It is not delayed, and is intended for the write-side buffer swap.
- Enable low:
  - Counters, lineBase and all pipeline stages load their reset values on the next edge.
  - Outputs go idle: syncs high, blank 1, RGB 0, address 0.
  - On re-enable, the scan restarts at (0,0).

## Timing
- Reset values: poul17RAddr=0, poul12Rgb=0, poul1HSync=1, poul1VSync=1, poul1Blank=1, poul1FrameDone=0, counters 0, lineBase 0.
- Pipeline latency:
  - Counter state to address: 1 cycle.
  - Counter state to RGB/sync/blank outputs: 3 cycles.
  - Sync and blank align exactly with the pixel data they frame.
- The first active pixel appears on the outputs 3 cycles after the first enabled cycle following reset release.
- The pipeline shift registers contain only idle values after reset, so there are no stale syncs or pixels.
- Frame period is 800×525 = 420000 cycles; line period is 800 cycles.
- Each buffer address is issued on 2 consecutive cycles, and each buffer row is used on 2 consecutive lines.
- Reset asserted mid-line: all outputs take reset values immediately (asynchronous). After release, the scan begins at (0,0).

## Test plan
- Reset/idle: assert piul1Reset, then hold piul1Enable=0 for 1000 cycles → HSync=VSync=1, Blank=1, Rgb=0, RAddr=0, FrameDone never pulses.
- Address doubling: enable from reset → RAddr sequence is 0,0,1,1,…,319,319 on line 0; identical on line 1; line 2 starts at 320; line 479 ends at 76799; RAddr=0 in blanking.
- Latency/data alignment: memory model returns data = address[11:0] one cycle later → Rgb equals the expected pixel value 3 cycles after the counter state; Blank falls exactly on the first pixel (value 0x000), and Rgb=0 whenever Blank=1.
- Sync placement: HSync low for exactly 96 cycles, starting 656+3 cycles after line start; VSync low for exactly 2×800 cycles, starting on line 490 (delayed 3 cycles).
- Frame wrap: run 2 frames → FrameDone pulses once per 420000 cycles, on cycle (799,524); line 0 of frame 2 restarts at RAddr 0.
- Mid-operation abort: drop Enable at (hcnt=300, vcnt=100), raise it 50 cycles later → outputs idle within 1 edge and the scan restarts at (0,0). Assert Reset at (hcnt=500, vcnt=200) → outputs reset asynchronously within the same cycle.
